pipe_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the MIPS five-stage pipeline. It replaces the fixed two-source, two-stage forwarding and stall logic. It keeps its own scoreboard of in-flight destination registers for the EX stage and FWD_DEPTH later stages. From that scoreboard it produces:
- forwarding selects for up to NSRC operands of the instruction in EX,
- load-use stalls,
- branch/jump flushes,
- optional multi-cycle (MUL/DIV) stalls.

---
 rtl/pipe_hazard_unit_if.sv | 59 +++++
 rtl/pipe_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: ID/EX hazard-control bundle.
// master = pipeline datapath, slave = pipe_hazard_unit.
interface pipe_hazard_unit_if #(
   parameter int AWIDTH    = 5,
   parameter int NSRC      = 2,
   parameter int FWD_DEPTH = 2
);
   localparam int SELW = $clog2(FWD_DEPTH + 1);

   logic                   i_id_valid;
   logic [NSRC*AWIDTH-1:0] i_id_src;
   logic [NSRC-1:0]        i_id_src_used;
   logic [AWIDTH-1:0]      i_id_rd;
   logic                   i_id_regwr;
   logic                   i_id_load;
   logic                   i_id_mul;
   logic                   i_ex_redirect;

   logic                   o_stall;
   logic                   o_flush_ifid;
   logic                   o_flush_idex;
   logic                   o_ex_hold;
   logic [NSRC*SELW-1:0]   o_fwd_sel;
   logic                   o_mdu_busy;

   modport master (
      output i_id_valid,
      output i_id_src,
      output i_id_src_used,
      output i_id_rd,
      output i_id_regwr,
      output i_id_load,
      output i_id_mul,
      output i_ex_redirect,
      input  o_stall,
      input  o_flush_ifid,
      input  o_flush_idex,
      input  o_ex_hold,
      input  o_fwd_sel,
      input  o_mdu_busy
   );

   modport slave (
      input  i_id_valid,
      input  i_id_src,
      input  i_id_src_used,
      input  i_id_rd,
      input  i_id_regwr,
      input  i_id_load,
      input  i_id_mul,
      input  i_ex_redirect,
      output o_stall,
      output o_flush_ifid,
      output o_flush_idex,
      output o_ex_hold,
      output o_fwd_sel,
      output o_mdu_busy
   );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based forwarding, load-use stall,
// redirect flush; multi-cycle MUL/DIV hold when HAZ_MDU_EN is defined.
module pipe_hazard_unit #(
   parameter int AWIDTH    = 5,
   parameter int NSRC      = 2,
   parameter int FWD_DEPTH = 2,
   parameter int MUL_LAT   = 4
) (
   input logic               d_clk,
   input logic               d_rst,
   pipe_hazard_unit_if.slave hz
);
   localparam int SELW = $clog2(FWD_DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic              regwr;
      logic              load;
      logic [AWIDTH-1:0] rd;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   slot_t                  slot_q [0:FWD_DEPTH];
   slot_t                  slot0_nxt;
   slot_t                  id_slot;
   logic [NSRC*AWIDTH-1:0] ex_src_q;
   logic [NSRC*AWIDTH-1:0] ex_src_nxt;
   logic [NSRC-1:0]        ex_used_q;
   logic [NSRC-1:0]        ex_used_nxt;

   logic                   run_q;
   logic                   mdu_busy;
   logic                   ex_hold;
   logic                   redirect;
   logic                   lu_hit;
   logic                   load_use;
   logic                   stall;
   logic                   issue;
   logic [NSRC*SELW-1:0]   fwd_sel;

   // Outputs stay quiet until one full cycle after reset release.
   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

`ifdef HAZ_MDU_EN
   localparam int CNTW = 4;

   logic [CNTW-1:0] mdu_cnt_q;

   assign mdu_busy = (mdu_cnt_q != '0);

   // Occupancy counter: loads when a MUL/DIV enters EX, counts down.
   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst)
         mdu_cnt_q <= '0;
      else if (mdu_busy)
         mdu_cnt_q <= mdu_cnt_q - CNTW'(1);
      else if (issue && hz.i_id_mul)
         mdu_cnt_q <= CNTW'(MUL_LAT - 1);
   end
`else
   localparam int unused_lat = MUL_LAT;

   logic unused_mul;

   assign unused_mul = hz.i_id_mul;
   assign mdu_busy   = 1'b0;
`endif

   // A redirect is squashed while a multi-cycle op owns EX.
   assign redirect = run_q & hz.i_ex_redirect & ~mdu_busy;
   assign ex_hold  = run_q & mdu_busy;
   assign stall    = run_q & ~redirect
                   & (load_use | mdu_busy);
   assign issue    = hz.i_id_valid & ~stall & ~redirect;

   assign id_slot = '{
      valid: 1'b1,
      regwr: hz.i_id_regwr,
      load:  hz.i_id_load,
      rd:    hz.i_id_rd
   };

   // Load in EX whose (non-zero) destination is read in ID.
   always_comb begin
      lu_hit = 1'b0;
      for (int n = 0; n < NSRC; n++) begin
         if (hz.i_id_src_used[n] &&
             hz.i_id_src[n*AWIDTH +: AWIDTH] == slot_q[0].rd)
            lu_hit = 1'b1;
      end
      load_use = hz.i_id_valid
               & slot_q[0].valid
               & slot_q[0].load
               & slot_q[0].regwr
               & (slot_q[0].rd != '0)
               & lu_hit;
   end

   // Youngest matching producer behind EX wins; a load one stage
   // behind EX has no data yet, so it is skipped.
   always_comb begin
      fwd_sel = '0;
      for (int n = 0; n < NSRC; n++) begin : g_op
         logic [AWIDTH-1:0] src;
         logic [SELW-1:0]   sel;
         src = ex_src_q[n*AWIDTH +: AWIDTH];
         sel = '0;
         if (ex_used_q[n] && src != '0) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
               if (slot_q[k].valid &&
                   slot_q[k].regwr &&
                   slot_q[k].rd == src &&
                   !(k == 1 && slot_q[k].load))
                  sel = SELW'(k);
            end
         end
         fwd_sel[n*SELW +: SELW] = sel;
      end
   end

   // EX slot: keep on hold, take the ID op on issue, else bubble.
   always_comb begin
      slot0_nxt   = BUBBLE;
      ex_src_nxt  = '0;
      ex_used_nxt = '0;
      unique case (1'b1)
         ex_hold: begin
            slot0_nxt   = slot_q[0];
            ex_src_nxt  = ex_src_q;
            ex_used_nxt = ex_used_q;
         end
         issue: begin
            slot0_nxt   = id_slot;
            ex_src_nxt  = hz.i_id_src;
            ex_used_nxt = hz.i_id_src_used;
         end
         default: ;
      endcase
   end

   // Scoreboard shift; a held EX op leaves a bubble behind it.
   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         for (int k = 0; k <= FWD_DEPTH; k++)
            slot_q[k] <= BUBBLE;
         ex_src_q  <= '0;
         ex_used_q <= '0;
      end else begin
         for (int k = FWD_DEPTH; k >= 2; k--)
            slot_q[k] <= slot_q[k-1];
         slot_q[1] <= ex_hold ? BUBBLE : slot_q[0];
         slot_q[0] <= slot0_nxt;
         ex_src_q  <= ex_src_nxt;
         ex_used_q <= ex_used_nxt;
      end
   end

   assign hz.o_stall      = stall;
   assign hz.o_flush_ifid = redirect;
   assign hz.o_flush_idex = redirect;
   assign hz.o_ex_hold    = ex_hold;
   assign hz.o_mdu_busy   = run_q & mdu_busy;
   assign hz.o_fwd_sel    = run_q ? fwd_sel : '0;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scenarios plus random traffic
// checked against a queue-based pipeline model.
module tb_pipe_hazard_unit;
   localparam int AW = 5;
   localparam int NS = 2;
   localparam int FD = 2;
   localparam int ML = 4;
   localparam int SW = $clog2(FD + 1);

   typedef struct packed {
      logic          valid;
      logic          regwr;
      logic          load;
      logic          mul;
      logic [AW-1:0] rd;
      logic [AW-1:0] src0;
      logic          u0;
      logic [AW-1:0] src1;
      logic          u1;
   } ins_t;

   logic d_clk;
   logic d_rst;
   int   checks;
   int   errors;
   logic [8:0] outs;

   ins_t pipe [$];
   int   m_left;
   bit   m_run;
   ins_t cur;
   bit   cur_redir;
   ins_t IDLE;

   pipe_hazard_unit_if #(
      .AWIDTH(AW), .NSRC(NS), .FWD_DEPTH(FD)
   ) hz ();

   pipe_hazard_unit #(
      .AWIDTH(AW), .NSRC(NS),
      .FWD_DEPTH(FD), .MUL_LAT(ML)
   ) dut (
      .d_clk(d_clk),
      .d_rst(d_rst),
      .hz(hz)
   );

   assign outs = {hz.o_stall, hz.o_flush_ifid,
                  hz.o_flush_idex, hz.o_ex_hold,
                  hz.o_mdu_busy, hz.o_fwd_sel};

   initial d_clk = 1'b0;
   always #5 d_clk = ~d_clk;

   function automatic ins_t mk(
      input int v, input int rd, input int wr,
      input int ld, input int ml,
      input int s0, input int u0,
      input int s1, input int u1);
      ins_t x;
      x.valid = (v != 0);
      x.rd    = AW'(rd);
      x.regwr = (wr != 0);
      x.load  = (ld != 0);
      x.mul   = (ml != 0);
      x.src0  = AW'(s0);
      x.u0    = (u0 != 0);
      x.src1  = AW'(s1);
      x.u1    = (u1 != 0);
      return x;
   endfunction

   function automatic logic [8:0] exp_o(
      input bit st, input bit fi, input bit fx,
      input bit h, input bit b, input int s0, input int s1);
      logic [SW-1:0] a;
      logic [SW-1:0] c;
      a = SW'(s0);
      c = SW'(s1);
      return {st, fi, fx, h, b, c, a};
   endfunction

   // ---------------- reference model ----------------
   function automatic bit m_busy();
`ifdef HAZ_MDU_EN
      return m_run && (m_left > 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_lu();
      ins_t s;
      bit   hit;
      s = pipe[0];
      hit = (cur.u0 && cur.src0 == s.rd) ||
            (cur.u1 && cur.src1 == s.rd);
      return cur.valid && s.valid && s.load &&
             s.regwr && s.rd != 0 && hit;
   endfunction

   function automatic bit m_redir();
      return m_run && cur_redir && !m_busy();
   endfunction

   function automatic bit m_stall();
      return m_run && !m_redir() && (m_lu() || m_busy());
   endfunction

   function automatic int m_sel(input int n);
      ins_t e;
      ins_t p;
      logic [AW-1:0] s;
      bit u;
      e = pipe[0];
      s = (n == 0) ? e.src0 : e.src1;
      u = (n == 0) ? e.u0 : e.u1;
      if (!m_run || !e.valid || !u || s == 0) return 0;
      for (int k = 1; k <= FD; k++) begin
         p = pipe[k];
         if (p.valid && p.regwr && p.rd == s &&
             !(k == 1 && p.load))
            return k;
      end
      return 0;
   endfunction

   function automatic logic [8:0] m_outs();
      return exp_o(m_stall(), m_redir(), m_redir(),
                   m_busy(), m_busy(), m_sel(0), m_sel(1));
   endfunction

   task automatic m_reset();
      pipe.delete();
      for (int i = 0; i <= FD; i++) pipe.push_back(IDLE);
      m_left = 0;
      m_run  = 1'b0;
   endtask

   task automatic m_step();
      bit hold;
      bit issue;
      if (!d_rst) return;
      hold  = m_busy();
      issue = cur.valid && !m_stall() && !m_redir();
      if (hold) begin
         pipe.insert(1, IDLE);
         m_left--;
      end else begin
         pipe.push_front(issue ? cur : IDLE);
`ifdef HAZ_MDU_EN
         if (issue && cur.mul) m_left = ML - 1;
`endif
      end
      while (pipe.size() > FD + 1) void'(pipe.pop_back());
      m_run = 1'b1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input ins_t x, input bit r);
      cur       = x;
      cur_redir = r;
      hz.i_id_valid    = x.valid;
      hz.i_id_rd       = x.rd;
      hz.i_id_regwr    = x.regwr;
      hz.i_id_load     = x.load;
      hz.i_id_mul      = x.mul;
      hz.i_id_src      = {x.src1, x.src0};
      hz.i_id_src_used = {x.u1, x.u0};
      hz.i_ex_redirect = r;
   endtask

   task automatic tick();
      m_step();
      @(posedge d_clk);
      #1;
   endtask

   task automatic do_reset();
      d_rst = 1'b0;
      m_reset();
      drive(IDLE, 1'b0);
      repeat (2) @(posedge d_clk);
      #1;
      d_rst = 1'b1;
      tick();
   endtask

   function automatic ins_t rnd_ins();
      return mk(($urandom_range(0, 9) < 8) ? 1 : 0,
                $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? 1 : 0,
                ($urandom_range(0, 11) == 0) ? 1 : 0,
                $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1));
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      d_rst = 1'b0;
      m_reset();
      drive(mk(1, 2, 1, 1, 0, 3, 1, 0, 0), 1'b1);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL reset_hold: got %b want %b", outs, 9'd0);
      end
      @(posedge d_clk);
      #1;
      d_rst = 1'b1;
      drive(IDLE, 1'b1);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL reset_first: got %b want %b", outs, 9'd0);
      end
      tick();
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 1, 1, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_run: got %b want %b",
                  outs, exp_o(0, 1, 1, 0, 0, 0, 0));
      end
      tick();
      drive(IDLE, 1'b0);
   endtask

   task automatic test_forward();
      do_reset();
      drive(mk(1, 1, 1, 0, 0, 2, 1, 3, 1), 1'b0);
      @(negedge d_clk);
      tick();
      drive(mk(1, 4, 1, 0, 0, 1, 1, 5, 1), 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL fwd_none: got %b want %b", outs, 9'd0);
      end
      tick();
      drive(mk(1, 6, 1, 0, 0, 1, 1, 1, 1), 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 0, 0, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL fwd_slot1: got %b want %b",
                  outs, exp_o(0, 0, 0, 0, 0, 1, 0));
      end
      tick();
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 0, 0, 0, 0, 2, 2)) begin
         errors++;
         $display("FAIL fwd_slot2: got %b want %b",
                  outs, exp_o(0, 0, 0, 0, 0, 2, 2));
      end
      tick();
   endtask

   task automatic test_load_use();
      ins_t dep;
      dep = mk(1, 3, 1, 0, 0, 2, 1, 2, 1);
      do_reset();
      drive(mk(1, 2, 1, 1, 0, 7, 1, 0, 0), 1'b0);
      @(negedge d_clk);
      tick();
      drive(dep, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(1, 0, 0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL lu_stall: got %b want %b",
                  outs, exp_o(1, 0, 0, 0, 0, 0, 0));
      end
      tick();
      drive(dep, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL lu_bubble: got %b want %b", outs, 9'd0);
      end
      tick();
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 0, 0, 0, 0, 2, 2)) begin
         errors++;
         $display("FAIL lu_fwd: got %b want %b",
                  outs, exp_o(0, 0, 0, 0, 0, 2, 2));
      end
      tick();
   endtask

   task automatic test_r0();
      do_reset();
      drive(mk(1, 0, 1, 1, 0, 4, 1, 0, 0), 1'b0);
      @(negedge d_clk);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive((i < 2) ? mk(1, i + 1, 1, 0, 0, 0, 1, 0, 1)
                       : IDLE, 1'b0);
         @(negedge d_clk);
         checks++;
         if (outs !== 9'd0) begin
            errors++;
            $display("FAIL r0_cyc%0d: got %b want %b",
                     i, outs, 9'd0);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      drive(mk(1, 2, 1, 1, 0, 7, 1, 0, 0), 1'b0);
      @(negedge d_clk);
      tick();
      drive(mk(1, 3, 1, 1, 0, 2, 1, 0, 0), 1'b1);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 1, 1, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL redir_prio: got %b want %b",
                  outs, exp_o(0, 1, 1, 0, 0, 0, 0));
      end
      tick();
      drive(mk(1, 4, 1, 0, 0, 3, 1, 3, 1), 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL redir_empty: got %b want %b", outs, 9'd0);
      end
      tick();
      drive(IDLE, 1'b0);
   endtask

   task automatic test_mdu();
      ins_t dep;
      dep = mk(1, 6, 1, 0, 0, 5, 1, 0, 0);
      do_reset();
      drive(mk(1, 5, 1, 0, 1, 1, 1, 2, 1), 1'b0);
      @(negedge d_clk);
      tick();
`ifdef HAZ_MDU_EN
      for (int i = 0; i < ML - 1; i++) begin
         drive(dep, i == 1);
         @(negedge d_clk);
         checks++;
         if (outs !== exp_o(1, 0, 0, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL mdu_busy%0d: got %b want %b",
                     i, outs, exp_o(1, 0, 0, 1, 1, 0, 0));
         end
         tick();
      end
      drive(dep, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL mdu_done: got %b want %b", outs, 9'd0);
      end
      tick();
`else
      drive(dep, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL mdu_off: got %b want %b", outs, 9'd0);
      end
      tick();
`endif
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 0, 0, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL mdu_fwd: got %b want %b",
                  outs, exp_o(0, 0, 0, 0, 0, 1, 0));
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(mk(1, 5, 1, 0, 1, 1, 1, 2, 1), 1'b0);
      @(negedge d_clk);
      tick();
      drive(mk(1, 6, 1, 0, 0, 5, 1, 0, 0), 1'b0);
      @(negedge d_clk);
      tick();
`ifdef HAZ_MDU_EN
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(1, 0, 0, 1, 1, 0, 0)) begin
         errors++;
         $display("FAIL rmid_cnt2: got %b want %b",
                  outs, exp_o(1, 0, 0, 1, 1, 0, 0));
      end
`else
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== exp_o(0, 0, 0, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL rmid_pre: got %b want %b",
                  outs, exp_o(0, 0, 0, 0, 0, 1, 0));
      end
`endif
      d_rst = 1'b0;
      cur_redir = 1'b1;
      hz.i_ex_redirect = 1'b1;
      #1;
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL rmid_async: got %b want %b", outs, 9'd0);
      end
      m_reset();
      repeat (2) @(posedge d_clk);
      #1;
      d_rst = 1'b1;
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL rmid_first: got %b want %b", outs, 9'd0);
      end
      tick();
      drive(mk(1, 7, 1, 0, 0, 5, 1, 6, 1), 1'b0);
      @(negedge d_clk);
      tick();
      drive(IDLE, 1'b0);
      @(negedge d_clk);
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL rmid_empty: got %b want %b", outs, 9'd0);
      end
      tick();
   endtask

   task automatic test_random();
      ins_t x;
      bit   keep;
      bit   kill;
      logic [8:0] e;
      keep = 1'b0;
      kill = 1'b0;
      x    = IDLE;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (kill)       x = IDLE;
         else if (!keep) x = rnd_ins();
         drive(x, $urandom_range(0, 15) == 0);
         @(negedge d_clk);
         e = m_outs();
         checks++;
         if (outs[8:4] !== e[8:4]) begin
            errors++;
            $display("FAIL rand_ctl%0d: got %b want %b",
                     c, outs[8:4], e[8:4]);
         end
         checks++;
         if (outs[3:0] !== e[3:0]) begin
            errors++;
            $display("FAIL rand_fwd%0d: got %b want %b",
                     c, outs[3:0], e[3:0]);
         end
         keep = m_stall();
         kill = m_redir();
         tick();
      end
      drive(IDLE, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      IDLE   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      d_rst  = 1'b0;
      m_reset();
      drive(IDLE, 1'b0);
      test_reset();
      test_forward();
      test_load_use();
      test_r0();
      test_redirect();
      test_mdu();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
